// File: rtl/enigma_pkg.sv
// enigma_pkg: shared types and constants for the Enigma key sequencer.
package enigma_pkg;
    typedef logic [1:0] setting_t;
    typedef logic [7:0] char_t;
    localparam char_t ASCII_A     = 8'h41;
    localparam char_t ASCII_Z     = 8'h5A;
    localparam char_t ASCII_a     = 8'h61;
    localparam char_t ASCII_z     = 8'h7A;
    localparam char_t CASE_OFFSET = 8'h20;
    localparam int    MAX_KEY     = 4;
    typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_t;
endpackage

// File: rtl/enigma_char_classify.sv
// enigma_char_classify: folds lowercase to uppercase and flags letters.
module enigma_char_classify (
    input  logic [7:0] s_data,
    output logic [7:0] norm_char,
    output logic       is_letter
);
    import enigma_pkg::*;
    logic upper, lower;
    always_comb begin
        upper     = (s_data >= ASCII_A) && (s_data <= ASCII_Z);
        lower     = (s_data >= ASCII_a) && (s_data <= ASCII_z);
        is_letter = upper || lower;
        norm_char = lower ? s_data - CASE_OFFSET : s_data;
    end
endmodule

// File: rtl/enigma_key_sequencer.sv
// enigma_key_sequencer: attaches rotating key settings to a normalised char stream.
module enigma_key_sequencer #(
    parameter int MAX_KEY = 4,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_load,
    input  logic [2*MAX_KEY-1:0] key_in,
    input  logic [2:0]           key_len,
    input  logic                 s_valid,
    input  logic [7:0]           s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [7:0]           m_char,
    output logic [1:0]           m_setting,
    output logic                 m_bypass,
    output logic                 m_last,
    output logic                 err_key,
    output logic                 busy,
    output logic [CNT_W-1:0]     msg_count
);
    import enigma_pkg::*;

    state_t               state_q, state_d;
    logic [2*MAX_KEY-1:0] key_q, key_d;
    logic [2:0]           len_q, len_d, idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 m_valid_q, m_valid_d;
    char_t                char_q, char_d;
    setting_t             set_q, set_d;
    logic                 byp_q, byp_d, last_q, last_d;
    char_t                norm_char;
    logic                 is_letter;
    setting_t             slot;
    logic                 accept, handshake, key_ok, loadable;

    enigma_char_classify u_classify (
        .s_data    (s_data),
        .norm_char (norm_char),
        .is_letter (is_letter)
    );

    always_comb begin
        slot = '0;
        for (int i = 0; i < MAX_KEY; i++)
            if (idx_q == 3'(i)) slot = key_q[2*(MAX_KEY-1-i) +: 2];
        key_ok    = (key_len != 3'd0) && ({29'd0, key_len} <= 32'(MAX_KEY));
        handshake = m_valid_q && m_ready;
        s_ready   = (state_q == ARMED || state_q == RUN) && (!m_valid_q || m_ready);
        accept    = s_valid && s_ready;
        // a beat accepted in ARMED wins over a coincident key_load
        loadable  = key_load && !accept && (state_q == IDLE || state_q == ARMED);
        state_d   = state_q;
        key_d     = key_q;
        len_d     = len_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        m_valid_d = m_valid_q;
        char_d    = char_q;
        set_d     = set_q;
        byp_d     = byp_q;
        last_d    = last_q;
        if (accept) begin
            m_valid_d = 1'b1;
            char_d    = norm_char;
            set_d     = slot;
            byp_d     = !is_letter;
            last_d    = s_last;
            state_d   = s_last ? DRAIN : RUN;
            if (is_letter) begin
                idx_d = (idx_q + 3'd1 == len_q) ? 3'd0 : idx_q + 3'd1;
                cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
            end
        end else if (handshake) begin
            m_valid_d = 1'b0;
        end
        if (state_q == DRAIN && handshake) begin
            state_d = ARMED;
            idx_d   = '0;
            cnt_d   = '0;
        end
        if (loadable) begin
            state_d = key_ok ? ARMED : IDLE;
            key_d   = key_ok ? key_in : '0;
            len_d   = key_ok ? key_len : 3'd0;
            err_d   = !key_ok;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            key_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            m_valid_q <= 1'b0;
            char_q    <= '0;
            set_q     <= '0;
            byp_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            m_valid_q <= m_valid_d;
            char_q    <= char_d;
            set_q     <= set_d;
            byp_q     <= byp_d;
            last_q    <= last_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_char    = char_q;
    assign m_setting = set_q;
    assign m_bypass  = byp_q;
    assign m_last    = last_q;
    assign err_key   = err_q;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign msg_count = cnt_q;
endmodule

// File: tb/tb_enigma_key_sequencer.sv
// tb_enigma_key_sequencer: randomized stream checks against a per-message reference model.
module tb_enigma_key_sequencer;
    logic       clk = 0, rst_n = 0, key_load = 0;
    logic [7:0] key_in = 0;
    logic [2:0] key_len = 0;
    logic       s_valid = 0, s_last = 0, m_ready = 0;
    logic [7:0] s_data = 0;
    logic       s_ready, m_valid, m_bypass, m_last, err_key, busy;
    logic [7:0] m_char, msg_count;
    logic [1:0] m_setting;
    int         errs = 0, checks = 0;
    logic [1:0] mkey [4];
    int         mlen = 1;

    typedef struct {
        logic [7:0] c;
        logic [1:0] s;
        logic       b;
        logic       l;
        int         cnt;
    } pair_t;

    enigma_key_sequencer dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in), .key_len(key_len),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_char(m_char), .m_setting(m_setting),
        .m_bypass(m_bypass), .m_last(m_last), .err_key(err_key), .busy(busy),
        .msg_count(msg_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_key(input logic [7:0] k, input logic [2:0] len);
        @(negedge clk);
        s_valid = 0; key_load = 1; key_in = k; key_len = len;
        @(negedge clk);
        key_load = 0;
        #1;
        if (len >= 1 && len <= 4) begin
            for (int i = 0; i < 4; i++) mkey[i] = k[7-2*i -: 2];
            mlen = int'(len);
            chk("err_key_clear", 32'(err_key), 0);
            chk("s_ready_armed", 32'(s_ready), 1);
        end else begin
            chk("err_key_set", 32'(err_key), 1);
            chk("s_ready_idle", 32'(s_ready), 0);
        end
        chk("busy_after_load", 32'(busy), 0);
    endtask

    task automatic run_msg(input string msg, input int stall, input int gap, input bit noise);
        pair_t exp[$];
        int n = msg.len(), i = 0, k = 0, idx = 0, cnt = 0, cyc = 0;
        bit pend = 0, done = 0, acc, hs, rdy;
        for (int j = 0; j < n; j++) begin
            logic [7:0] c = msg[j];
            bit up = (c >= 8'h41 && c <= 8'h5A);
            bit lo = (c >= 8'h61 && c <= 8'h7A);
            pair_t p;
            p.c = lo ? c - 8'h20 : c;
            p.s = mkey[idx];
            p.b = !(up || lo);
            p.l = (j == n - 1);
            if (!p.b) begin
                idx = (idx + 1) % mlen;
                cnt = cnt < 255 ? cnt + 1 : 255;
            end
            p.cnt = cnt;
            exp.push_back(p);
        end
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            s_valid  = (i < n) && ($urandom_range(99) >= 32'(gap));
            s_data   = (i < n) ? msg[i] : 8'h00;
            s_last   = (i == n - 1);
            m_ready  = $urandom_range(99) >= 32'(stall);
            key_load = noise && (i > 0 || s_valid) && ($urandom_range(3) == 0);
            key_len  = 3'd0;
            key_in   = 8'($urandom);
            #1;
            rdy = (i < n) && (!pend || m_ready);
            chk("m_valid", 32'(m_valid), 32'(pend));
            chk("s_ready", 32'(s_ready), 32'(rdy));
            chk("busy", 32'(busy), 32'(i > 0));
            chk("err_key_quiet", 32'(err_key), 0);
            if (pend) begin
                chk("m_char", 32'(m_char), 32'(exp[k].c));
                chk("m_setting", 32'(m_setting), 32'(exp[k].s));
                chk("m_bypass", 32'(m_bypass), 32'(exp[k].b));
                chk("m_last", 32'(m_last), 32'(exp[k].l));
                chk("msg_count", 32'(msg_count), 32'(exp[k].cnt));
            end
            acc = s_valid && rdy;
            hs  = pend && m_ready;
            if (hs) begin
                if (k == n - 1) done = 1;
                k++;
            end
            if (acc) i++;
            pend = acc ? 1'b1 : (hs ? 1'b0 : pend);
        end
        chk("msg_done", 32'(done), 1);
        @(negedge clk);
        s_valid = 0; s_last = 0; key_load = 0;
        #1;
        chk("armed_busy", 32'(busy), 0);
        chk("armed_m_valid", 32'(m_valid), 0);
        chk("armed_count", 32'(msg_count), 0);
        chk("armed_s_ready", 32'(s_ready), 1);
    endtask

    initial begin
        string t = "ABCDEFGHIJ";
        m_ready = 1;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err_key", 32'(err_key), 0);
        chk("rst_count", 32'(msg_count), 0);
        rst_n = 1;
        @(negedge clk);
        s_valid = 1; s_data = 8'h41;
        #1;
        chk("idle_s_ready", 32'(s_ready), 0);
        s_valid = 0;
        load_key(8'b10_01_00_11, 3'd4);
        run_msg("HELLOWORLD", 0, 0, 0);
        run_msg("he llo", 0, 0, 0);
        run_msg("Enigma, MkIII!", 60, 20, 1);
        load_key(8'b10_01_00_11, 3'd0);
        load_key(8'b10_01_00_11, 3'd5);
        load_key(8'b11_01_00_00, 3'd2);
        run_msg("ABC", 30, 10, 0);
        load_key(8'b10_01_00_11, 3'd4);
        m_ready = 1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            s_valid = 1; s_data = t[j]; s_last = 0;
        end
        @(negedge clk);
        s_valid = 0;
        #1;
        chk("pre_rst_count", 32'(msg_count), 4);
        rst_n = 0;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 0);
        chk("mid_rst_m_char", 32'(m_char), 0);
        chk("mid_rst_m_setting", 32'(m_setting), 0);
        chk("mid_rst_m_bypass", 32'(m_bypass), 0);
        chk("mid_rst_m_last", 32'(m_last), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_count", 32'(msg_count), 0);
        chk("mid_rst_s_ready", 32'(s_ready), 0);
        @(negedge clk);
        rst_n = 1; s_valid = 1; s_data = t[4];
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("post_rst_s_ready", 32'(s_ready), 0);
            chk("post_rst_m_valid", 32'(m_valid), 0);
        end
        s_valid = 0;
        load_key(8'b10_00_00_00, 3'd1);
        run_msg("Z", 0, 0, 0);
        run_msg("az", 20, 0, 0);
        load_key(8'b10_01_00_11, 3'd4);
        run_msg("Q", 0, 0, 0);
        run_msg("AB", 0, 0, 0);
        for (int r = 0; r < 25; r++) begin
            string s = "";
            int len = int'($urandom_range(20, 1));
            if ($urandom_range(3) == 0) load_key(8'($urandom), 3'($urandom_range(7, 5)));
            load_key(8'($urandom), 3'($urandom_range(4, 1)));
            for (int j = 0; j < len; j++)
                s = $sformatf("%s%c", s, 8'($urandom_range(126, 32)));
            run_msg(s, int'($urandom_range(50)), int'($urandom_range(50)), 1'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/enigma_key_sequencer.md
Name: enigma_key_sequencer

Overview:
- Upstream feeder for the modified Enigma mapping core (8-bit ASCII char in, 2-bit setting in, combinational out).
- Accepts a message as a valid/ready byte stream plus a programmable key of up to four 2-bit settings (e.g. "2103").
- Normalises each character and attaches the per-character setting, rotating through the key one slot per letter.
- Presents a registered char/setting pair to the core with its own valid/ready handshake.

Parameters:
- MAX_KEY, 4, number of key slots; key_len is valid in the range 1..MAX_KEY.
- CNT_W, 8, width of the saturating letter counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_load  in  1  single-cycle pulse; captures key_in and key_len.
- key_in  in  2*MAX_KEY  slot0 = [7:6], slot1 = [5:4], slot2 = [3:2], slot3 = [1:0]; "2103" = 8'b10_01_00_11.
- key_len  in  3  number of active slots.
- s_valid  in  1  input character valid.
- s_data  in  8  ASCII character.
- s_last  in  1  marks the final character of the message.
- s_ready  out  1  sequencer can accept a beat.
- m_valid  out  1  output pair valid.
- m_ready  in  1  core/consumer accepts the pair.
- m_char  out  8  normalised character.
- m_setting  out  2  setting for m_char.
- m_bypass  out  1  m_char is not a letter; consumer passes it through unencrypted.
- m_last  out  1  final character of the message.
- err_key  out  1  sticky flag: last key_load was illegal.
- busy  out  1  state is RUN or DRAIN.
- msg_count  out  CNT_W  letters emitted in the current message, saturating.

Behaviour:
- Reset: all outputs are 0, state = IDLE, key register = 0, slot index = 0.
- States:
  - IDLE: no valid key held.
  - ARMED: key held, waiting for the first beat.
  - RUN: message in progress.
  - DRAIN: last beat is captured and waiting for m_ready.
- key_load:
  - Honoured only in IDLE or ARMED; ignored in RUN and DRAIN (no flag raised).
  - key_len 1..MAX_KEY: capture key, clear err_key, go to ARMED.
  - key_len 0 or > MAX_KEY: set err_key, go to IDLE; the old key is discarded.
- s_ready = (state is ARMED or RUN) && (!m_valid || m_ready). Full throughput is one beat per cycle.
- A beat is accepted when s_valid && s_ready. The output register loads on the next edge, so latency is 1 cycle.
  - m_valid holds, and all m_* outputs stay stable, until m_valid && m_ready.
- Character rules:
  - 'A'..'Z': m_char = s_data, m_bypass = 0.
  - 'a'..'z': m_char = s_data - 8'h20, m_bypass = 0.
  - Anything else: m_char = s_data, m_bypass = 1.
- Setting rotation:
  - m_setting = key slot[idx] for every beat, including bypass beats.
  - idx advances (idx+1 == key_len ? 0 : idx+1) on accepted letter beats only.
  - Bypass beats do not advance idx.
  - msg_count increments on accepted letters and saturates at 2^CNT_W-1.
- Transitions:
  - ARMED -> RUN on the first accept without s_last.
  - ARMED/RUN -> DRAIN on an accept with s_last.
  - DRAIN -> ARMED when the last pair handshakes; idx resets to 0 and msg_count resets to 0 on the same edge.
- A single-character message (s_last on the first beat) goes ARMED -> DRAIN directly.
- Simultaneous key_load and accepted beat in ARMED: the beat is accepted with the old key, and key_load is ignored.
- A reset mid-message drops the in-flight pair and returns to IDLE; the key must be reloaded.

Decomposition:
- Package enigma_pkg:
  - setting_t (2-bit) and char_t (8-bit) types.
  - Constants ASCII_A, ASCII_Z, ASCII_a, ASCII_z, CASE_OFFSET = 8'h20, MAX_KEY.
  - State enum IDLE/ARMED/RUN/DRAIN.
- Sub-module enigma_char_classify: combinational; s_data -> normalised char plus is_letter.
- Top level holds the FSM, key register, idx, counter and output register.

Test Plan:
- Load key 8'b10_01_00_11, len 4; stream "HELLOWORLD" with m_ready = 1 -> m_setting sequence 2,1,0,3,2,1,0,3,2,1; m_last on 'D'; msg_count = 10; back in ARMED.
- Same key; send "he llo" -> m_char "HE LLO"; the space has m_bypass = 1 and setting 0; letter settings are 2,1,0,3,2.
- Hold m_ready = 0 for 3 cycles mid-stream -> s_ready = 0, m_* stable, no beat lost or duplicated; the sequence resumes correctly.
- key_load with key_len = 0 -> err_key = 1, state IDLE, s_ready = 0; then a legal load with len 2 (key 2'b11, 2'b01) -> err_key = 0; "ABC" gives settings 3,1,3.
- Assert rst_n low after the 4th character of a 10-char message -> all outputs 0 immediately; after release s_ready = 0 until key_load.
- Single-char message 'Z' with s_last, key len 1 = 2'b10 -> one pair {Z, 2, last}; DRAIN -> ARMED; the next message restarts at slot 0.
